regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 69 ++++++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default widths, enable levels
// and the hardwired zero-register address.
package regfile_mp_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNumLog2 = 5;
    localparam int RegNum     = 1 << RegNumLog2;

    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam logic [RegAddrBus-1:0] ZeroAddr = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-address masking, optional same-edge write bypass
// (REGFILE_BYPASS_EN) and the rdata/rbusy output registers.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegNumLog2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     busy_pre,
`ifdef REGFILE_BYPASS_EN
    input  logic                     busy_post,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
`endif
    output logic [DATA_W-1:0]        rdata,
    output logic                     rbusy
);

    logic [DATA_W-1:0] sel_data;
    logic              sel_busy;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rbusy_d, rbusy_q;

    always_comb begin
        sel_data = mem_data;
        sel_busy = busy_pre;
`ifdef REGFILE_BYPASS_EN
        // Later ports overwrite earlier matches so the highest-index writer wins.
        sel_busy = busy_post;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WriteEnable && waddr[i*ADDR_W +: ADDR_W] == raddr) begin
                sel_data = wdata[i*DATA_W +: DATA_W];
            end
        end
`endif
        rdata_d = rdata_q;
        rbusy_d = rbusy_q;
        if (re == ReadEnable) begin
            if (raddr == ADDR_W'(ZeroAddr)) begin
                rdata_d = '0;
                rbusy_d = 1'b0;
            end else begin
                rdata_d = sel_data;
                rbusy_d = sel_busy;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            rbusy_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
        end
    end

    assign rdata = rdata_q;
    assign rbusy = rbusy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, hardwired x0 and a per-register
// busy scoreboard. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegNumLog2,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    input  logic                     flush
);

    localparam int DEPTH = (ADDR_W == RegNumLog2) ? RegNum : (1 << ADDR_W);

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_d, busy_q;

    // Ports are applied in index order so the highest-index writer wins a conflict.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WriteEnable && waddr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZeroAddr)) begin
                mem_d[waddr[i*ADDR_W +: ADDR_W]] = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A new producer (busy_set) supersedes a same-cycle writeback clear; flush beats both.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] == WriteEnable) begin
                    busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (busy_set) begin
                busy_d[busy_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .re       (re[j]),
            .raddr    (raddr[j*ADDR_W +: ADDR_W]),
            .mem_data (mem_q[raddr[j*ADDR_W +: ADDR_W]]),
            .busy_pre (busy_q[raddr[j*ADDR_W +: ADDR_W]]),
`ifdef REGFILE_BYPASS_EN
            .busy_post(busy_d[raddr[j*ADDR_W +: ADDR_W]]),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
`endif
            .rdata    (rdata[j*DATA_W +: DATA_W]),
            .rbusy    (rbusy[j])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp (2 read, 2 write ports) against a
// register-level reference model with an expected-response queue.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int EW = NR * (DW + 1);

    logic             clk;
    logic             rst;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             busy_set;
    logic [AW-1:0]    busy_addr;
    logic             flush;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    logic [DW-1:0] m_reg  [32];
    logic          m_busy [32];
    logic [DW-1:0] m_rd   [NR];
    logic          m_rb   [NR];

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .busy_set(busy_set), .busy_addr(busy_addr), .flush(flush)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        for (int j = 0; j < NR; j++) begin
            m_rd[j] = '0;
            m_rb[j] = 1'b0;
        end
    endtask

    // driver tasks
    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        re = '0; raddr = '0;
        busy_set = 1'b0; busy_addr = '0; flush = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic bset(input int a);
        busy_set  = 1'b1;
        busy_addr = AW'(a);
    endtask

    // Reference model: evaluates this cycle's inputs, queues the outputs expected
    // after the coming edge, then advances the architectural state.
    task automatic commit();
        logic [DW-1:0] n_reg [32];
        logic          n_busy[32];
        logic [EW-1:0] e;
        int a;
        n_reg  = m_reg;
        n_busy = m_busy;
        for (int p = 0; p < NW; p++) begin
            a = int'(waddr[p*AW +: AW]);
            if (we[p] && a != 0) n_reg[a] = wdata[p*DW +: DW];
        end
        if (flush) begin
            for (int k = 0; k < 32; k++) n_busy[k] = 1'b0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (we[p]) n_busy[int'(waddr[p*AW +: AW])] = 1'b0;
            end
            if (busy_set && busy_addr != 0) n_busy[int'(busy_addr)] = 1'b1;
        end
        for (int j = 0; j < NR; j++) begin
            if (re[j]) begin
                a = int'(raddr[j*AW +: AW]);
                if (a == 0) begin
                    m_rd[j] = '0;
                    m_rb[j] = 1'b0;
                end else begin
`ifdef REGFILE_BYPASS_EN
                    m_rd[j] = n_reg[a];
                    m_rb[j] = n_busy[a];
`else
                    m_rd[j] = m_reg[a];
                    m_rb[j] = m_busy[a];
`endif
                end
            end
        end
        for (int j = 0; j < NR; j++) begin
            e[j*DW +: DW] = m_rd[j];
            e[NR*DW + j]  = m_rb[j];
        end
        exp_q.push_back(e);
        m_reg  = n_reg;
        m_busy = n_busy;
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int j = 0; j < NR; j++) begin
                    chk($sformatf("rdata%0d", j), rdata[j*DW +: DW], e[j*DW +: DW]);
                    chk($sformatf("rbusy%0d", j), DW'(rbusy[j]), DW'(e[NR*DW + j]));
                end
            end
        end
    end

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        #12;
        chk("reset_rdata", rdata[DW-1:0], '0);
        chk("reset_rdata1", rdata[2*DW-1:DW], '0);
        chk("reset_rbusy", DW'(rbusy), '0);
        @(negedge clk);
        rst = 1'b1;

        // basic write / read, x0 writes ignored
        next(); wr(0, 3, 32'hDEADBEEF); commit();
        next(); rd(0, 3); commit();
        next(); wr(1, 0, 32'h1234); commit();
        next(); rd(1, 0); commit();

        // same-edge write and read of x7
        next(); wr(0, 7, 32'h11); commit();
        next(); wr(0, 7, 32'hA5A5A5A5); rd(0, 7); commit();
        next(); rd(1, 7); commit();

        // write conflict: port 1 wins
        next(); wr(0, 9, 32'h1); wr(1, 9, 32'h2); commit();
        next(); rd(0, 9); commit();

        // busy scoreboard
        next(); bset(4); commit();
        next(); rd(0, 4); commit();
        next(); wr(0, 4, 32'h44); commit();
        next(); rd(0, 4); commit();
        next(); bset(4); wr(1, 4, 32'h45); commit();
        next(); rd(1, 4); commit();
        next(); bset(0); rd(0, 0); commit();
        next(); bset(6); commit();
        next(); flush = 1'b1; bset(5); commit();
        next(); rd(0, 4); rd(1, 6); commit();
        next(); rd(0, 5); commit();

        // hold while re is low
        next(); bset(3); commit();
        next(); rd(0, 3); rd(1, 9); commit();
        for (int c = 0; c < 3; c++) begin
            next();
            raddr = NR*AW'($urandom);
            wr(0, 3, $urandom);
            commit();
        end

        // random traffic
        for (int c = 0; c < 400; c++) begin
            next();
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 2) == 0) wr(p, $urandom_range(0, 7), $urandom);
            end
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) != 0) rd(p, $urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) bset($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) flush = 1'b1;
            commit();
        end

        // asynchronous reset mid-run
        next(); wr(0, 5, 32'hCAFEF00D); bset(5); commit();
        next(); rd(0, 5); rd(1, 5); commit();
        next();
        #2 rst = 1'b0;
        #1;
        chk("async_rdata0", rdata[DW-1:0], '0);
        chk("async_rdata1", rdata[2*DW-1:DW], '0);
        chk("async_rbusy", DW'(rbusy), '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        next(); rd(0, 5); rd(1, 5); commit();
        next(); wr(0, 5, 32'h55); rd(0, 5); commit();
        next(); rd(1, 5); commit();

        repeat (4) next();
        chk("queue_drained", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
